reg_bank_write: RTL
===================

Name: reg_bank_write

Overview:
- Upstream stage of the 8-to-1 register read path: owns the eight 32-bit general registers and drives their contents continuously on from_reg0..from_reg7.
- Register writes from the ALU/DMA side arrive over a valid/ready handshake.
- Writes are buffered in a small in-order FIFO and committed to the register array one per cycle.
- Commits pause while the consumer asserts hold, so a multi-cycle read or transfer sees stable register values.

Parameters:
- DEPTH, 4, write FIFO entries; power of two, 2..16.
- PTR_W, 2, pointer width = log2(DEPTH).
- CNT_W, 3, occupancy counter width = log2(DEPTH)+1.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  FIFO can accept a write this cycle.
- wr_addr  input  3  destination register index 0..7.
- wr_data  input  32  value to write.
- hold  input  1  1 = suspend commits; registers frozen.
- from_reg0 .. from_reg7  output  32 each  registered contents of registers 0..7.
- pending  output  CNT_W  number of buffered, uncommitted writes.
- idle  output  1  pending == 0.

Behaviour:
- Reset (asynchronous on reset_n low, takes effect immediately; release is synchronous to clk):
  - all eight registers = 0.
  - FIFO pointers = 0, pending = 0, idle = 1, wr_ready = 1.
  - Any in-flight or buffered writes are discarded; reset mid-operation leaves no partial commit.
- Accept:
  - wr_ready = (pending != DEPTH). It is a combinational function of state only, never of wr_valid or hold.
  - An entry {wr_addr, wr_data} is pushed at an edge where wr_valid && wr_ready.
  - When wr_ready = 0, wr_valid/addr/data are ignored. The requester must hold them stable until accepted.
- Commit:
  - At an edge where pending != 0 && !hold, the head entry is written to register[addr] and popped.
  - At most one commit per cycle.
- Latency:
  - A write accepted at edge N into an empty FIFO, with hold low at edge N+1, commits at edge N+1.
  - The new value appears on from_regX after edge N+1, i.e. 2 cycles from the first wr_valid assertion.
  - There is no bypass: a write never lands in the same edge it is accepted.
- Simultaneous accept and commit in the same edge:
  - Both occur; pending is unchanged.
  - Exception when full: wr_ready = 0, so no accept even though a slot is freed that edge.
- Ordering:
  - Strict FIFO order.
  - Multiple writes to the same address commit in order; the last one accepted wins.
- Hold:
  - Freezes commits only. Accepts continue until full.
  - Deassertion resumes commits on the next edge.
- Pointer wrap-around:
  - Pointers are PTR_W bits and wrap modulo DEPTH.
  - Full/empty are decided from pending, not from pointer equality.
- Outputs:
  - from_regN are direct register outputs (no combinational path from inputs).
  - pending and idle are registered/state-derived.

Optional Feature:
- Macro REG0_ZERO_EN.
- Defined:
  - Register 0 is hardwired zero; from_reg0 is constant 0.
  - Writes to address 0 are still accepted and occupy a FIFO slot. At commit they are popped but discarded.
  - pending and ordering are unaffected.
- Undefined: register 0 is an ordinary writable register like 1..7.

Test Plan:
1. Reset: hold reset_n low mid-stream with 3 entries pending -> immediately all from_regN = 0, pending = 0, idle = 1, wr_ready = 1. After release, no buffered write ever commits.
2. Single write, hold = 0: wr_addr = 5, wr_data = 32'hDEADBEEF accepted at edge N -> pending = 1 after N. from_reg5 = DEADBEEF and pending = 0 after N+1; other registers remain 0.
3. Fill under hold: hold = 1, push writes to addr 0..3 with data 1..4 -> wr_ready = 0 after 4th accept, pending = 4. A 5th request (addr 7, data 9) waits.
   - Release hold -> regs 0..3 = 1..4 on four consecutive edges.
   - The 5th write is accepted on the first commit edge following wr_ready re-asserting, then commits; from_reg7 = 9.
4. Streaming: wr_valid held high for 10 cycles, hold = 0, addr = i mod 8, data = i -> pending never exceeds 1, wr_ready stays 1. Final from_reg0 = 8, from_reg1 = 9, from_reg2..7 = 2..7.
5. Same-address ordering plus wrap: hold = 1, push addr 6 with data A, B, C, D; release hold; then push E -> from_reg6 sequence A, B, C, D, E; pointers wrap with no loss.
6. REG0_ZERO_EN: write 32'h12345678 to addr 0 and 32'h1 to addr 1 -> with the macro, from_reg0 stays 0 and from_reg1 = 1. Without the macro, from_reg0 = 12345678.

Source files
------------

// File: rtl/reg_bank_write.sv
// Eight 32-bit register bank fed by an in-order write FIFO. Build macro: REG0_ZERO_EN (register 0 hardwired to zero).

// Generic in-order FIFO; occupancy count is the single source of full/empty.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: the caller qualifies push/pop; no internal overflow protection.
module reg_bank_fifo #(
   parameter int W     = 35,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     push_dat,
   output logic [W-1:0]     head_dat,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   // Storage is not reset: a zero count makes stale contents unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_dat = mem[rptr];

endmodule

// Register bank: buffers writes and commits one per cycle unless hold is high.
// Latency: accept at edge N, commit at edge N+1 at the earliest; value visible 2 cycles after wr_valid.
// Backpressure: wr_ready = FIFO not full (state only); hold freezes commits while accepts continue.
module reg_bank_write #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [2:0]       wr_addr,
   input  logic [31:0]      wr_data,
   input  logic             hold,
   output logic [31:0]      from_reg0,
   output logic [31:0]      from_reg1,
   output logic [31:0]      from_reg2,
   output logic [31:0]      from_reg3,
   output logic [31:0]      from_reg4,
   output logic [31:0]      from_reg5,
   output logic [31:0]      from_reg6,
   output logic [31:0]      from_reg7,
   output logic [CNT_W-1:0] pending,
   output logic             idle
);

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] data;
   } wr_entry_t;

   wr_entry_t   push_ent;
   wr_entry_t   head_ent;
   logic        accept;
   logic        commit;
   logic [31:0] regs [1:7];

   assign wr_ready = (pending != CNT_W'(DEPTH));
   assign idle     = (pending == '0);
   assign accept   = wr_valid && wr_ready;
   assign commit   = (pending != '0) && !hold;
   assign push_ent = '{addr: wr_addr, data: wr_data};

   reg_bank_fifo #(
      .W     ($bits(wr_entry_t)),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (accept),
      .pop      (commit),
      .push_dat (push_ent),
      .head_dat (head_ent),
      .count    (pending)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < 8; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int i = 1; i < 8; i++) begin
            if (head_ent.addr == 3'(i)) regs[i] <= head_ent.data;
         end
      end
   end

`ifdef REG0_ZERO_EN
   // Address-0 entries still drain through the FIFO; their data is simply dropped.
   assign from_reg0 = '0;
`else
   logic [31:0] reg0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              reg0 <= '0;
      else if (commit && head_ent.addr == 3'd0)  reg0 <= head_ent.data;
   end

   assign from_reg0 = reg0;
`endif

   assign from_reg1 = regs[1];
   assign from_reg2 = regs[2];
   assign from_reg3 = regs[3];
   assign from_reg4 = regs[4];
   assign from_reg5 = regs[5];
   assign from_reg6 = regs[6];
   assign from_reg7 = regs[7];

endmodule
